if_block: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core; sits directly upstream of the decode stage and supplies the `ir` word it decodes. Holds the PC, drives a synchronous 1-cycle-latency instruction memory, and buffers returned words in a 2-entry queue so decode stalls never lose a fetched instruction. Redirects from the execute stage flush the queue and discard any in-flight response.

---
 rtl/if_block_pkg.sv | 15 +
 rtl/if_block_fetch_queue.sv | 34 +++
 rtl/if_block.sv | 70 +++++++
 tb/tb_if_block.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/if_block_pkg.sv
// if_block_pkg: shared fetch-stage types and constants
package if_block_pkg;
  localparam int IF_QDEPTH = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } if_entry_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ex_reg_d;
endpackage

// File: rtl/if_block_fetch_queue.sv
// fetch_queue: 2-entry fetch buffer whose head keeps its last value when empty
module fetch_queue
  import if_block_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  if_entry_t din,
  output if_entry_t head,
  output logic [1:0] count
);
  localparam logic [1:0] FULL = 2'(IF_QDEPTH);
  if_entry_t tail;
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '{pc: RESET_PC, instr: NOP_INSTR, exc: 1'b0};
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= {1'b0, push};
      if (push) head <= din;
    end else begin
      assert (!(push && !pop && count == FULL));
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && (count == 2'd0 || (pop && count == 2'd1))) head <= din;
      else if (pop && count == FULL) head <= tail;
      if (push && (count == FULL || (!pop && count == 2'd1))) tail <= din;
    end
  end
endmodule

// File: rtl/if_block.sv
// if_block: instruction fetch stage with 2-entry queue; IF_MISALIGN_EXC_EN enables misaligned-redirect exception entries
module if_block
  import if_block_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_rden,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_exc
);
  logic [31:0] pc, req_pc;
  logic inflight, kill, halted, mis, pop, push;
  logic [1:0] count;
  logic [2:0] occ;
  if_entry_t head, din;
`ifdef IF_MISALIGN_EXC_EN
  assign mis = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign if_valid  = count != 2'd0;
  assign pop       = if_valid && !stall;
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign imem_rden = !reset && !redirect && !halted && occ < 3'd2;
  assign imem_addr = pc;
  assign push      = redirect ? mis : inflight && !kill;
  assign din       = redirect ? if_entry_t'{pc: redirect_pc, instr: NOP_INSTR, exc: 1'b1}
                              : if_entry_t'{pc: req_pc, instr: imem_data, exc: 1'b0};
  assign ir        = if_valid ? head.instr : NOP_INSTR;
  assign if_pc     = head.pc;
  assign if_exc    = if_valid && head.exc;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      inflight <= imem_rden;
      kill     <= redirect && inflight;
      if (redirect) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        halted <= mis;
      end else if (imem_rden) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
    end
  end
  fetch_queue #(.RESET_PC(RESET_PC)) u_queue (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop && !redirect),
    .flush(redirect),
    .din  (din),
    .head (head),
    .count(count)
  );
endmodule

// File: tb/tb_if_block.sv
// tb_if_block: directed cycle-by-cycle check of fetch, stall, redirect, wrap and reset
module tb_if_block;
  logic clk = 1'b0;
  logic reset, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data, ir, if_pc;
  logic imem_rden, if_valid, if_exc;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_rden) imem_data <= imem_addr;
  if_block u_dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_rden  (imem_rden),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .ir         (ir),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .if_exc     (if_exc)
  );
  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset = r;
    stall = s;
    redirect = rd;
    redirect_pc = rpc;
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_data = '0;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("rst_rden", imem_rden, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_ir", ir, 32'h13);
    chk("rst_pc", if_pc, 0);
    chk("rst_exc", if_exc, 0);
    drive(0, 0, 0, 0);
    chk("r0_rden", imem_rden, 1);
    chk("r0_addr", imem_addr, 0);
    chk("r0_valid", if_valid, 0);
    drive(0, 0, 0, 0);
    chk("r1_addr", imem_addr, 4);
    chk("r1_valid", if_valid, 0);
    drive(0, 0, 0, 0);
    chk("r2_valid", if_valid, 1);
    chk("r2_pc", if_pc, 0);
    chk("r2_ir", ir, 0);
    drive(0, 0, 0, 0);
    chk("r3_pc", if_pc, 4);
    drive(0, 1, 0, 0);
    chk("st0_pc", if_pc, 8);
    chk("st0_rden", imem_rden, 0);
    drive(0, 1, 0, 0);
    chk("st1_pc", if_pc, 8);
    chk("st1_rden", imem_rden, 0);
    drive(0, 1, 0, 0);
    chk("st2_pc", if_pc, 8);
    chk("st2_rden", imem_rden, 0);
    drive(0, 0, 0, 0);
    chk("rel_pc", if_pc, 8);
    chk("rel_rden", imem_rden, 1);
    chk("rel_addr", imem_addr, 16);
    drive(0, 0, 0, 0);
    chk("rel1_pc", if_pc, 12);
    drive(0, 0, 0, 0);
    chk("rel2_pc", if_pc, 16);
    drive(0, 0, 1, 32'h100);
    chk("rd_pc", if_pc, 20);
    chk("rd_rden", imem_rden, 0);
    drive(0, 0, 0, 0);
    chk("rd1_valid", if_valid, 0);
    chk("rd1_rden", imem_rden, 1);
    chk("rd1_addr", imem_addr, 32'h100);
    drive(0, 0, 0, 0);
    chk("rd2_valid", if_valid, 0);
    chk("rd2_addr", imem_addr, 32'h104);
    drive(0, 0, 0, 0);
    chk("rd3_valid", if_valid, 1);
    chk("rd3_pc", if_pc, 32'h100);
    chk("rd3_ir", ir, 32'h100);
    drive(0, 1, 0, 0);
    chk("fs0_pc", if_pc, 32'h104);
    chk("fs0_rden", imem_rden, 0);
    drive(0, 1, 0, 0);
    chk("fs1_pc", if_pc, 32'h104);
    chk("fs1_rden", imem_rden, 0);
    drive(0, 1, 1, 32'h200);
    chk("rs_rden", imem_rden, 0);
    drive(0, 0, 0, 0);
    chk("rs1_valid", if_valid, 0);
    chk("rs1_addr", imem_addr, 32'h200);
    chk("rs1_rden", imem_rden, 1);
    drive(0, 0, 0, 0);
    chk("rs2_valid", if_valid, 0);
    drive(0, 0, 0, 0);
    chk("rs3_pc", if_pc, 32'h200);
    chk("rs3_valid", if_valid, 1);
    drive(0, 0, 1, 32'hFFFF_FFF8);
    drive(0, 0, 0, 0);
    chk("wr1_addr", imem_addr, 32'hFFFF_FFF8);
    drive(0, 0, 0, 0);
    chk("wr2_addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0);
    chk("wr3_pc", if_pc, 32'hFFFF_FFF8);
    chk("wr3_addr", imem_addr, 0);
    drive(0, 0, 0, 0);
    chk("wr4_pc", if_pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0);
    chk("wr5_pc", if_pc, 0);
    chk("wr5_ir", ir, 0);
    drive(0, 0, 1, 32'h102);
`ifdef IF_MISALIGN_EXC_EN
    drive(0, 0, 0, 0);
    chk("mx1_valid", if_valid, 1);
    chk("mx1_pc", if_pc, 32'h102);
    chk("mx1_ir", ir, 32'h13);
    chk("mx1_exc", if_exc, 1);
    chk("mx1_rden", imem_rden, 0);
    drive(0, 0, 0, 0);
    chk("mx2_valid", if_valid, 0);
    chk("mx2_rden", imem_rden, 0);
    chk("mx2_exc", if_exc, 0);
    drive(0, 0, 1, 32'h200);
    drive(0, 0, 0, 0);
    chk("mx4_rden", imem_rden, 1);
    chk("mx4_addr", imem_addr, 32'h200);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("mx6_pc", if_pc, 32'h200);
    chk("mx6_valid", if_valid, 1);
    chk("mx6_exc", if_exc, 0);
`else
    drive(0, 0, 0, 0);
    chk("ma1_valid", if_valid, 0);
    chk("ma1_rden", imem_rden, 1);
    chk("ma1_addr", imem_addr, 32'h100);
    drive(0, 0, 0, 0);
    chk("ma2_addr", imem_addr, 32'h104);
    drive(0, 0, 0, 0);
    chk("ma3_pc", if_pc, 32'h100);
    chk("ma3_ir", ir, 32'h100);
    chk("ma3_exc", if_exc, 0);
`endif
    drive(1, 1, 1, 32'h300);
    chk("mr0_rden", imem_rden, 0);
    drive(0, 0, 0, 0);
    chk("mr1_valid", if_valid, 0);
    chk("mr1_pc", if_pc, 0);
    chk("mr1_rden", imem_rden, 1);
    chk("mr1_addr", imem_addr, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("mr3_valid", if_valid, 1);
    chk("mr3_pc", if_pc, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
